// File: rtl/calc_sequencer.sv
// Four-digit two-operand calculator controller: button conditioning, BCD digit
// entry, and an add/sub/mul/div sequencer with a 7-step restoring divider.

module calc_db #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  logic s1, s2, deb, deb_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; deb <= 1'b0; deb_d <= 1'b0; pulse <= 1'b0;
      cnt <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      if (s2 == deb)
        cnt <= '0;
      else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module calc_sequencer #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  B,
  output logic [14:0] result,
  output logic        dot,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {ENTRY, EXEC, SHOW} st_t;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  logic [8:0] pulse;
  for (genvar i = 0; i < 9; i++) begin : g_db
    calc_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(B[i]), .pulse(pulse[i]));
  end

  st_t state, state_nxt;
  logic [3:0][3:0] d, d_nxt;
  logic [3:0]  dig;
  logic        op_go, div_done, ge;
  logic [1:0]  op_sel, op_r;
  logic [6:0]  a_cur, b_cur, a_nxt, b_nxt, a_r, b_r, rem, q, rem_nx, q_nx;
  logic [7:0]  rem_sh;
  logic [2:0]  cnt;
  logic [13:0] entry_val;
  logic [14:0] arith;

  // Digit pulses are dropped during EXEC and whenever any op button fires alongside.
  always_comb begin
    dig    = (state != EXEC && !(|pulse[8:4])) ? pulse[3:0] : 4'b0;
    op_go  = (|pulse[7:4]) && !pulse[8];
    op_sel = pulse[7] ? OP_DIV : pulse[6] ? OP_MUL : pulse[5] ? OP_SUB : OP_ADD;
    for (int i = 0; i < 4; i++)
      d_nxt[i] = dig[i] ? ((d[i] == 4'd9) ? 4'd0 : d[i] + 4'd1) : d[i];
  end

  assign a_cur     = 7'(d[0]) * 7'd10 + 7'(d[1]);
  assign b_cur     = 7'(d[2]) * 7'd10 + 7'(d[3]);
  assign a_nxt     = 7'(d_nxt[0]) * 7'd10 + 7'(d_nxt[1]);
  assign b_nxt     = 7'(d_nxt[2]) * 7'd10 + 7'(d_nxt[3]);
  assign entry_val = 14'(a_nxt) * 14'd100 + 14'(b_nxt);

  // One restoring step: shift next dividend bit into the partial remainder.
  assign rem_sh = {rem, q[6]};
  assign ge     = rem_sh >= {1'b0, b_r};
  assign rem_nx = ge ? 7'(rem_sh - {1'b0, b_r}) : rem_sh[6:0];
  assign q_nx   = {q[5:0], ge};

  always_comb begin
    case (op_r)
      OP_ADD:  arith = 15'(a_r) + 15'(b_r);
      OP_SUB:  arith = (a_r >= b_r) ? 15'(a_r - b_r) : {1'b1, 14'(b_r - a_r)};
      OP_MUL:  arith = 15'(a_r) * 15'(b_r);
      default: arith = '0;
    endcase
  end

  assign div_done = (op_r != OP_DIV) || (b_r == 7'd0) || (cnt == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ENTRY:   if (op_go) state_nxt = EXEC;
      EXEC:    if (div_done) state_nxt = SHOW;
      SHOW:    if (pulse[8] || (|dig)) state_nxt = ENTRY;
               else if (op_go) state_nxt = EXEC;
      default: state_nxt = ENTRY;
    endcase
  end

  always_comb begin
    busy = (state == EXEC);
    dot  = (state == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0; result <= '0; err <= 1'b0;
      a_r <= '0; b_r <= '0; op_r <= OP_ADD; rem <= '0; q <= '0; cnt <= '0;
    end else begin
      d <= d_nxt;
      if (state_nxt == ENTRY) result <= {1'b0, entry_val};
      if (state == SHOW && state_nxt == ENTRY) err <= 1'b0;
      if (state != EXEC && state_nxt == EXEC) begin
        a_r <= a_cur; b_r <= b_cur; op_r <= op_sel; err <= 1'b0;
        rem <= '0; q <= a_cur; cnt <= '0;
      end
      if (state == EXEC) begin
        if (op_r != OP_DIV)
          result <= arith;
        else if (b_r == 7'd0) begin
          err    <= 1'b1;
          result <= '0;
        end else begin
          rem <= rem_nx;
          q   <= q_nx;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) result <= 15'(q_nx);
        end
      end
    end
  end
endmodule
